// File: rtl/simd_alu_arbiter_if.sv
// rtl/simd_alu_arbiter_if.sv - request, ALU and response buses of the SIMD ALU arbiter
interface simd_alu_arbiter_if #(
  parameter int NUM_REQ         = 4,
  parameter int SIMD_DATA_WIDTH = 256,
  parameter int SIMD_OPC_WIDTH  = 4
);
  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int FLAG_W = SIMD_DATA_WIDTH / 8;

  logic                                en;
  logic [NUM_REQ-1:0]                  req_valid;
  logic [NUM_REQ-1:0]                  req_ready;
  logic [NUM_REQ*SIMD_DATA_WIDTH-1:0]  req_a;
  logic [NUM_REQ*SIMD_DATA_WIDTH-1:0]  req_b;
  logic [NUM_REQ*SIMD_OPC_WIDTH-1:0]   req_opcode;

  logic [SIMD_DATA_WIDTH-1:0]          alu_a;
  logic [SIMD_DATA_WIDTH-1:0]          alu_b;
  logic [SIMD_OPC_WIDTH-1:0]           alu_opcode;
  logic [SIMD_DATA_WIDTH-1:0]          alu_out;
  logic [FLAG_W-1:0]                   alu_ovf;
  logic [FLAG_W-1:0]                   alu_udf;

  logic                                rsp_valid;
  logic                                rsp_ready;
  logic [ID_W-1:0]                     rsp_id;
  logic [SIMD_DATA_WIDTH-1:0]          rsp_data;
  logic [FLAG_W-1:0]                   rsp_ovf;
  logic [FLAG_W-1:0]                   rsp_udf;
  logic                                idle;

  // Arbiter side
  modport slave (
    input  en, req_valid, req_a, req_b, req_opcode, alu_out, alu_ovf, alu_udf, rsp_ready,
    output req_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_id, rsp_data, rsp_ovf, rsp_udf, idle
  );

  // Requesters, ALU and response consumer side
  modport master (
    output en, req_valid, req_a, req_b, req_opcode, alu_out, alu_ovf, alu_udf, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_id, rsp_data, rsp_ovf, rsp_udf, idle
  );
endinterface

// File: rtl/simd_alu_arbiter.sv
// rtl/simd_alu_arbiter.sv - round-robin arbiter sharing one pipelined SIMD ALU, with tagged result FIFO
module simd_alu_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int SIMD_DATA_WIDTH = 256,
  parameter int SIMD_OPC_WIDTH  = 4,
  parameter int ALU_LATENCY     = 2,
  parameter int RSP_DEPTH       = 4
) (
  input logic               clk,
  input logic               rst,
  simd_alu_arbiter_if.slave bus
);
  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int FLAG_W = SIMD_DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W  = $clog2(RSP_DEPTH);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(RSP_DEPTH);

  logic [ID_W-1:0]            rr_ptr;
  logic [ID_W-1:0]            winner;
  logic [ID_W-1:0]            scan_idx;
  logic                       found;
  logic                       credit;
  logic                       xfer;
  logic                       push;
  logic                       pop;
  logic                       fifo_nonempty;
  logic [CNT_W-1:0]           inflight_cnt;
  logic [CNT_W-1:0]           fifo_cnt;
  logic [ALU_LATENCY:0]       tag_valid;
  logic [ID_W-1:0]            tag_id   [ALU_LATENCY+1];
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [ID_W-1:0]            mem_id   [RSP_DEPTH];
  logic [SIMD_DATA_WIDTH-1:0] mem_data [RSP_DEPTH];
  logic [FLAG_W-1:0]          mem_ovf  [RSP_DEPTH];
  logic [FLAG_W-1:0]          mem_udf  [RSP_DEPTH];

  // A slot is reserved for every op from grant until its result leaves the FIFO,
  // so the FIFO can never overflow. Registered counts only: a pop frees credit next cycle.
  assign credit        = ({1'b0, inflight_cnt} + {1'b0, fifo_cnt}) < DEPTH_C;
  assign xfer          = bus.en && credit && found && !rst;
  assign push          = tag_valid[ALU_LATENCY];
  assign fifo_nonempty = (fifo_cnt != '0);
  assign pop           = fifo_nonempty && bus.rsp_ready;

  // Round-robin scan: first valid requester at or after rr_ptr, wrapping upward.
  always_comb begin
    found    = 1'b0;
    winner   = rr_ptr;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && bus.req_valid[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  // One-hot accept for the winner only when a grant is allowed this cycle.
  always_comb begin
    bus.req_ready = '0;
    if (xfer) bus.req_ready = NUM_REQ'(1) << winner;
  end

  // Pointer moves just past the winner so it becomes lowest priority next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rr_ptr <= '0;
    else if (xfer) rr_ptr <= (winner == LAST_ID) ? '0 : winner + ID_W'(1);
  end

  // Register the winner's operands towards the ALU; hold them between grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_opcode <= '0;
    end else if (xfer) begin
      bus.alu_a      <= bus.req_a[int'(winner)*SIMD_DATA_WIDTH +: SIMD_DATA_WIDTH];
      bus.alu_b      <= bus.req_b[int'(winner)*SIMD_DATA_WIDTH +: SIMD_DATA_WIDTH];
      bus.alu_opcode <= bus.req_opcode[int'(winner)*SIMD_OPC_WIDTH +: SIMD_OPC_WIDTH];
    end
  end

  // Tag pipeline: the last stage lines up with alu_out for the op it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid <= '0;
      for (int i = 0; i <= ALU_LATENCY; i++) tag_id[i] <= '0;
    end else begin
      tag_valid <= {tag_valid[ALU_LATENCY-1:0], xfer};
      tag_id[0] <= winner;
      for (int i = 1; i <= ALU_LATENCY; i++) tag_id[i] <= tag_id[i-1];
    end
  end

  // Occupancy counters: in-flight ops and buffered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_cnt <= '0;
      fifo_cnt     <= '0;
    end else begin
      case ({xfer, push})
        2'b10:   inflight_cnt <= inflight_cnt + CNT_W'(1);
        2'b01:   inflight_cnt <= inflight_cnt - CNT_W'(1);
        default: inflight_cnt <= inflight_cnt;
      endcase
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Result FIFO read/write pointers, wrapping at the configured depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
    end
  end

  // Result storage; contents are only observed through the valid-gated head.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[wr_ptr]   <= tag_id[ALU_LATENCY];
      mem_data[wr_ptr] <= bus.alu_out;
      mem_ovf[wr_ptr]  <= bus.alu_ovf;
      mem_udf[wr_ptr]  <= bus.alu_udf;
    end
  end

  // FIFO head drives the response port; fields read zero while empty.
  always_comb begin
    bus.rsp_valid = fifo_nonempty;
    bus.rsp_id    = '0;
    bus.rsp_data  = '0;
    bus.rsp_ovf   = '0;
    bus.rsp_udf   = '0;
    if (fifo_nonempty) begin
      bus.rsp_id   = mem_id[rd_ptr];
      bus.rsp_data = mem_data[rd_ptr];
      bus.rsp_ovf  = mem_ovf[rd_ptr];
      bus.rsp_udf  = mem_udf[rd_ptr];
    end
    bus.idle = (inflight_cnt == '0) && !fifo_nonempty;
  end
endmodule

// File: tb/tb_simd_alu_arbiter.sv
// tb/tb_simd_alu_arbiter.sv - vector table, directed corner cases and random run against a queue model
module tb_simd_alu_arbiter;
  localparam int NR    = 4;
  localparam int DW    = 256;
  localparam int OW    = 4;
  localparam int L     = 2;
  localparam int DEPTH = 4;
  localparam int FW    = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  simd_alu_arbiter_if #(.NUM_REQ(NR), .SIMD_DATA_WIDTH(DW), .SIMD_OPC_WIDTH(OW)) bus ();

  simd_alu_arbiter #(
    .NUM_REQ(NR), .SIMD_DATA_WIDTH(DW), .SIMD_OPC_WIDTH(OW), .ALU_LATENCY(L), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [FW-1:0] o;
    logic [FW-1:0] u;
  } res_t;

  // Stand-in ALU: op 0 = byte add (carry -> ovf), op 1 = byte sub (borrow -> udf), others zero.
  function automatic res_t alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [OW-1:0] op);
    res_t r;
    logic [8:0] s;
    r = '0;
    for (int i = 0; i < FW; i++) begin
      if (op == 0) begin
        s = {1'b0, a[8*i+:8]} + {1'b0, b[8*i+:8]};
        r.d[8*i+:8] = s[7:0];
        r.o[i] = s[8];
      end else if (op == 1) begin
        s = {1'b0, a[8*i+:8]} - {1'b0, b[8*i+:8]};
        r.d[8*i+:8] = s[7:0];
        r.u[i] = s[8];
      end
    end
    return r;
  endfunction

  // Two-register ALU pipeline: result of operands seen in cycle c appears in cycle c+2.
  res_t alu_s1 = '0;
  res_t alu_s2 = '0;
  always @(posedge clk) begin
    alu_s1 <= alu_fn(bus.alu_a, bus.alu_b, bus.alu_opcode);
    alu_s2 <= alu_s1;
  end
  assign bus.alu_out = alu_s2.d;
  assign bus.alu_ovf = alu_s2.o;
  assign bus.alu_udf = alu_s2.u;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] rnd_wide();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[32*i+:32] = $urandom;
    return v;
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < NR; i++) begin
      bus.req_a[i*DW+:DW]      = rnd_wide();
      bus.req_b[i*DW+:DW]      = rnd_wide();
      bus.req_opcode[i*OW+:OW] = OW'($urandom_range(0, 3));
    end
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_id"}, bus.rsp_id, 0);
    chk({tag, "_rsp_data"}, bus.rsp_data, 0);
    chk({tag, "_rsp_ovf"}, bus.rsp_ovf, 0);
    chk({tag, "_rsp_udf"}, bus.rsp_udf, 0);
    chk({tag, "_alu_a"}, bus.alu_a, 0);
    chk({tag, "_alu_b"}, bus.alu_b, 0);
    chk({tag, "_alu_opcode"}, bus.alu_opcode, 0);
    chk({tag, "_idle"}, bus.idle, 1);
  endtask

  // Reset with every requester asking, so req_ready must be forced low by rst itself.
  task automatic do_reset();
    bus.req_valid = '1;
    bus.en        = 1'b1;
    bus.rsp_ready = 1'b0;
    #2 rst = 1'b1;
    #1 reset_chk("rst");
    nxt();
    nxt();
    bus.req_valid = '0;
    rst = 1'b0;
    nxt();
  endtask

  typedef struct {
    int           id;
    logic [7:0]   a;
    logic [7:0]   b;
    logic [OW-1:0] op;
    logic [7:0]   exp_d;
    logic         exp_o;
    logic         exp_u;
  } vec_t;

  typedef struct {
    int   id;
    int   due;
    res_t r;
  } ent_t;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1);
  end

  initial begin : main
    vec_t vt[6];
    ent_t infl[$];
    ent_t mf[$];
    ent_t e;
    int   lat, n, win, idx, m_rr;
    logic credit;

    bus.en = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    rand_ops();
    #1 reset_chk("por");
    do_reset();

    // Single-op vectors: latency, id routing and byte-lane results.
    vt[0] = '{0, 8'h01, 8'h02, 4'd0, 8'h03, 1'b0, 1'b0};
    vt[1] = '{2, 8'hF0, 8'h20, 4'd0, 8'h10, 1'b1, 1'b0};
    vt[2] = '{1, 8'h05, 8'h07, 4'd1, 8'hFE, 1'b0, 1'b1};
    vt[3] = '{3, 8'h09, 8'h04, 4'd1, 8'h05, 1'b0, 1'b0};
    vt[4] = '{1, 8'h7F, 8'h01, 4'd0, 8'h80, 1'b0, 1'b0};
    vt[5] = '{2, 8'hAA, 8'h55, 4'd9, 8'h00, 1'b0, 1'b0};
    foreach (vt[v]) begin
      rand_ops();
      bus.req_a[vt[v].id*DW+:DW]      = {FW{vt[v].a}};
      bus.req_b[vt[v].id*DW+:DW]      = {FW{vt[v].b}};
      bus.req_opcode[vt[v].id*OW+:OW] = vt[v].op;
      bus.req_valid = NR'(1) << vt[v].id;
      bus.rsp_ready = 1'b1;
      smp();
      chk("vec_ready", bus.req_ready, NR'(1) << vt[v].id);
      nxt();
      bus.req_valid = '0;
      smp();
      lat = 1;
      while (!bus.rsp_valid && lat < 20) begin
        nxt();
        smp();
        lat++;
      end
      chk("vec_latency", lat, 4);
      chk("vec_rsp_id", bus.rsp_id, vt[v].id);
      chk("vec_rsp_data", bus.rsp_data, {FW{vt[v].exp_d}});
      chk("vec_rsp_ovf", bus.rsp_ovf, {FW{vt[v].exp_o}});
      chk("vec_rsp_udf", bus.rsp_udf, {FW{vt[v].exp_u}});
      nxt();
      smp();
      chk("vec_after_pop_valid", bus.rsp_valid, 0);
      chk("vec_after_pop_idle", bus.idle, 1);
      nxt();
    end

    // Fairness: all requesters always valid, grants must rotate 0,1,2,3,...
    do_reset();
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 12; c++) begin
      smp();
      if (bus.req_ready != '0) begin
        chk("fair_grant", bus.req_ready, NR'(1) << (n % NR));
        n++;
      end
      nxt();
    end
    chk("fair_count", n, 12);

    // Backpressure: exactly DEPTH grants, then one pop buys exactly one grant a cycle later.
    do_reset();
    bus.req_valid = '1;
    bus.rsp_ready = 1'b0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      smp();
      if (bus.req_ready != '0) n++;
      nxt();
    end
    chk("bp_grants", n, DEPTH);
    bus.rsp_ready = 1'b1;
    smp();
    chk("bp_pop_cycle_ready", bus.req_ready, 0);
    chk("bp_pop_id", bus.rsp_id, 0);
    nxt();
    bus.rsp_ready = 1'b0;
    smp();
    chk("bp_regrant", bus.req_ready, 4'b0001);
    chk("bp_next_head", bus.rsp_id, 1);
    nxt();
    smp();
    chk("bp_no_second", bus.req_ready, 0);
    nxt();

    // Push and pop in the same cycle with two results buffered.
    do_reset();
    bus.req_valid = 4'b0111;
    bus.rsp_ready = 1'b0;
    smp(); chk("pp_grant0", bus.req_ready, 4'b0001); nxt();
    smp(); chk("pp_grant1", bus.req_ready, 4'b0010); nxt();
    smp(); chk("pp_grant2", bus.req_ready, 4'b0100); nxt();
    bus.req_valid = '0;
    smp(); chk("pp_c3_valid", bus.rsp_valid, 0); nxt();
    smp(); chk("pp_c4_valid", bus.rsp_valid, 1); chk("pp_c4_id", bus.rsp_id, 0); nxt();
    bus.rsp_ready = 1'b1;
    smp(); chk("pp_c5_id", bus.rsp_id, 0); nxt();
    smp(); chk("pp_c6_valid", bus.rsp_valid, 1); chk("pp_c6_id", bus.rsp_id, 1); nxt();
    smp(); chk("pp_c7_valid", bus.rsp_valid, 1); chk("pp_c7_id", bus.rsp_id, 2); nxt();
    smp(); chk("pp_c8_valid", bus.rsp_valid, 0); chk("pp_c8_idle", bus.idle, 1); nxt();

    // en dropped with two ops in flight: no grants, both results drain, then idle.
    do_reset();
    bus.req_valid = 4'b0011;
    bus.rsp_ready = 1'b1;
    smp(); chk("en_grant0", bus.req_ready, 4'b0001); nxt();
    smp(); chk("en_grant1", bus.req_ready, 4'b0010); nxt();
    bus.en = 1'b0;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      smp();
      chk("en_off_ready", bus.req_ready, 0);
      if (bus.rsp_valid) begin
        chk("en_rsp_id", bus.rsp_id, n);
        n++;
      end
      nxt();
    end
    chk("en_rsp_count", n, 2);
    smp();
    chk("en_idle", bus.idle, 1);
    nxt();
    bus.en = 1'b1;

    // Reset pulse with three ops outstanding.
    do_reset();
    bus.req_valid = 4'b0111;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      smp();
      nxt();
    end
    bus.req_valid = '1;
    #2 rst = 1'b1;
    #1 reset_chk("mid");
    nxt();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      smp();
      chk("mid_no_rsp", bus.rsp_valid, 0);
      chk("mid_idle", bus.idle, 1);
      nxt();
    end
    bus.req_valid = 4'b1001;
    smp();
    chk("mid_first_grant", bus.req_ready, 4'b0001);
    nxt();
    bus.req_valid = '0;

    // Random run against a transaction-level model: ops wait in an in-flight queue
    // until their due cycle, then move to the result queue.
    do_reset();
    m_rr = 0;
    for (int c = 0; c < 500; c++) begin
      rand_ops();
      bus.req_valid = NR'($urandom);
      bus.en        = ($urandom % 8) != 0;
      bus.rsp_ready = ($urandom % 3) != 0;
      if (c >= 480) begin
        bus.en = 1'b0;
        bus.rsp_ready = 1'b1;
      end
      smp();
      credit = (infl.size() + mf.size()) < DEPTH;
      win = -1;
      if (bus.en && credit) begin
        for (int k = 0; k < NR; k++) begin
          idx = (m_rr + k) % NR;
          if (win < 0 && bus.req_valid[idx]) win = idx;
        end
      end
      chk("rnd_ready", bus.req_ready, (win < 0) ? 0 : (1 << win));
      chk("rnd_rsp_valid", bus.rsp_valid, mf.size() != 0);
      chk("rnd_idle", bus.idle, (infl.size() == 0) && (mf.size() == 0));
      if (mf.size() != 0) begin
        chk("rnd_rsp_id", bus.rsp_id, mf[0].id);
        chk("rnd_rsp_data", bus.rsp_data, mf[0].r.d);
        chk("rnd_rsp_ovf", bus.rsp_ovf, mf[0].r.o);
        chk("rnd_rsp_udf", bus.rsp_udf, mf[0].r.u);
      end
      if (bus.rsp_ready && mf.size() != 0) void'(mf.pop_front());
      while (infl.size() != 0 && infl[0].due == c) mf.push_back(infl.pop_front());
      if (win >= 0) begin
        e.id  = win;
        e.due = c + L + 1;
        e.r   = alu_fn(bus.req_a[win*DW+:DW], bus.req_b[win*DW+:DW], bus.req_opcode[win*OW+:OW]);
        infl.push_back(e);
        m_rr = (win + 1) % NR;
      end
      nxt();
    end
    smp();
    chk("rnd_final_idle", bus.idle, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
